// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue slice.
// Holds the instruction word layout, opcode and unit encodings (unit codes
// match the reservation-station encoding), the dispatch field bundle, the
// dispatch FSM state type and the imm16 sign-extension helper.
package issue_queue_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned REG_SIZE  = 6;

  // Instruction field bit positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 28;
  localparam int unsigned RD_MSB  = 27;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS1_MSB = 21;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_MSB = 15;
  localparam int unsigned RS2_LSB = 10;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_LW   = 4'h0;
  localparam logic [3:0] OP_LWI  = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_SWI  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_MULI = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'hF;

  typedef enum logic [1:0] {
    UNIT_LW  = 2'b00,
    UNIT_SW  = 2'b01,
    UNIT_ADD = 2'b10,
    UNIT_MUL = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  typedef struct packed {
    unit_e                 unit;
    logic [REG_SIZE-1:0]   reg1;
    logic [REG_SIZE-1:0]   reg2;
    logic [REG_SIZE-1:0]   reg3;
    logic                  hasimm;
    logic [WORD_SIZE-1:0]  imm;
  } dispatch_t;

  function automatic logic [WORD_SIZE-1:0] sext_imm16(input logic [15:0] imm16);
    return {{(WORD_SIZE-16){imm16[15]}}, imm16};
  endfunction

endpackage

// File: rtl/issue_queue_decode.sv
// Combinational decoder for one instruction word.
// Ports:
//   instr      in  : instruction word
//   disp       out : reservation-station dispatch fields
//   is_nop     out : opcode 1111, word is dropped silently
//   is_illegal out : opcode 1000-1110, word is dropped and flagged
module issue_decode
  import issue_queue_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dispatch_t          disp,
  output logic               is_nop,
  output logic               is_illegal
);

  logic [3:0]  opcode;
  logic [15:0] imm16;

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign imm16  = instr[IMM_MSB:IMM_LSB];

  always_comb begin
    disp       = '0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;

    unique case (opcode)
      OP_LW,  OP_LWI:  disp.unit = UNIT_LW;
      OP_SW,  OP_SWI:  disp.unit = UNIT_SW;
      OP_ADD, OP_ADDI: disp.unit = UNIT_ADD;
      OP_MUL, OP_MULI: disp.unit = UNIT_MUL;
      OP_NOP:          is_nop     = 1'b1;
      default:         is_illegal = 1'b1;
    endcase

    disp.hasimm = opcode[0];
    disp.reg1   = REG_SIZE'(instr[RD_MSB:RD_LSB]);
    disp.reg2   = REG_SIZE'(instr[RS1_MSB:RS1_LSB]);
    // rs2 and imm16 overlap; only the one selected by hasimm is exposed
    if (disp.hasimm) begin
      disp.imm = sext_imm16(imm16);
    end else begin
      disp.reg3 = REG_SIZE'(instr[RS2_MSB:RS2_LSB]);
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Instruction buffer and dispatcher in front of the reservation station.
// Fetch pushes 32-bit words through a valid/ready handshake into a circular
// FIFO. The head word is decoded and dispatched with a one-cycle rs_enable
// pulse; the RS answers with rs_accept one cycle later. A reject retries the
// same head word; nop and illegal words are popped without dispatch.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_instr   : fetch push request and word
//   in_ready            : FIFO has space (registered)
//   rs_*                : registered dispatch fields and rs_enable strobe
//   rs_accept           : RS response, sampled in the CHECK state
//   illegal             : sticky, an undefined opcode was dropped
//   stall_cnt           : saturating count of rejected dispatches
//   count               : FIFO occupancy
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STALL_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     in_ready,
  output logic [1:0]               rs_unit,
  output logic [REG_SIZE-1:0]      rs_reg1,
  output logic [REG_SIZE-1:0]      rs_reg2,
  output logic [REG_SIZE-1:0]      rs_reg3,
  output logic                     rs_hasimm,
  output logic [WORD_SIZE-1:0]     rs_imm,
  output logic                     rs_enable,
  input  logic                     rs_accept,
  output logic                     illegal,
  output logic [STALL_W-1:0]       stall_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];

  state_e             state_q,     state_d;
  logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]   count_q,     count_d;
  logic               in_ready_q,  in_ready_d;
  dispatch_t          disp_q,      disp_d;
  logic               rs_enable_q, rs_enable_d;
  logic               illegal_q,   illegal_d;
  logic [STALL_W-1:0] stall_q,     stall_d;

  logic      push;
  logic      pop;
  dispatch_t head_disp;
  logic      head_nop;
  logic      head_illegal;

  issue_decode u_decode (
    .instr      (mem_q[rd_ptr_q]),
    .disp       (head_disp),
    .is_nop     (head_nop),
    .is_illegal (head_illegal)
  );

  assign push = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    disp_d      = disp_q;
    rs_enable_d = 1'b0;
    illegal_d   = illegal_q;
    stall_d     = stall_q;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          if (head_nop || head_illegal) begin
            pop = 1'b1;
            if (head_illegal) illegal_d = 1'b1;
          end else begin
            // Fields are captured on entry to ISSUE so the outputs are
            // registered and held stable through CHECK and any retries.
            disp_d      = head_disp;
            rs_enable_d = 1'b1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (rs_accept) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (stall_q != '1) stall_d = stall_q + STALL_W'(1);
          rs_enable_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (pop && !push) count_d = count_q - CNT_W'(1);

    in_ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      disp_q      <= '0;
      rs_enable_q <= 1'b0;
      illegal_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      disp_q      <= disp_d;
      rs_enable_q <= rs_enable_d;
      illegal_q   <= illegal_d;
      stall_q     <= stall_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  assign in_ready  = in_ready_q;
  assign rs_unit   = disp_q.unit;
  assign rs_reg1   = disp_q.reg1;
  assign rs_reg2   = disp_q.reg2;
  assign rs_reg3   = disp_q.reg3;
  assign rs_hasimm = disp_q.hasimm;
  assign rs_imm    = disp_q.imm;
  assign rs_enable = rs_enable_q;
  assign illegal   = illegal_q;
  assign stall_cnt = stall_q;
  assign count     = count_q;

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: a scoreboard of expected dispatches
// is filled as legal words are accepted by the FIFO and drained by an RS
// responder that compares every rs_enable pulse against the queue head.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned STALL_W = 16;

  typedef struct packed {
    logic [1:0]           unit;
    logic [REG_SIZE-1:0]  r1;
    logic [REG_SIZE-1:0]  r2;
    logic [REG_SIZE-1:0]  r3;
    logic                 hasimm;
    logic [WORD_SIZE-1:0] imm;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic [31:0]            in_instr = '0;
  logic                   in_ready;
  logic [1:0]             rs_unit;
  logic [REG_SIZE-1:0]    rs_reg1, rs_reg2, rs_reg3;
  logic                   rs_hasimm;
  logic [WORD_SIZE-1:0]   rs_imm;
  logic                   rs_enable;
  logic                   rs_accept = 1'b0;
  logic                   illegal;
  logic [STALL_W-1:0]     stall_cnt;
  logic [$clog2(DEPTH):0] count;

  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  int   rej_left = 0;
  bit   hold_rs = 1'b0;
  exp_t exp_q[$];

  issue_queue #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .rs_unit   (rs_unit),
    .rs_reg1   (rs_reg1),
    .rs_reg2   (rs_reg2),
    .rs_reg3   (rs_reg3),
    .rs_hasimm (rs_hasimm),
    .rs_imm    (rs_imm),
    .rs_enable (rs_enable),
    .rs_accept (rs_accept),
    .illegal   (illegal),
    .stall_cnt (stall_cnt),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] w);
    exp_t m;
    m.unit   = w[30:29];
    m.hasimm = w[28];
    m.r1     = w[27:22];
    m.r2     = w[21:16];
    m.r3     = m.hasimm ? '0 : w[15:10];
    m.imm    = m.hasimm ? {{16{w[15]}}, w[15:0]} : '0;
    return m;
  endfunction

  // RS responder: checks each dispatch and answers in the following cycle.
  always @(negedge clk) begin
    if (rst_n && rs_enable) begin
      exp_t got;
      got = {rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm};
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dispatch_unexpected: got %h, required no dispatch", got);
        rs_accept = 1'b1;
      end else begin
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL dispatch_fields: got %h, required %h", got, exp_q[0]);
        end
        if (!hold_rs && rej_left == 0) begin
          rs_accept = 1'b1;
          void'(exp_q.pop_front());
        end else begin
          rs_accept = 1'b0;
          if (rej_left > 0) rej_left--;
        end
      end
    end
  end

  // Called at a negedge; drives one word for one cycle.
  task automatic push_word(input logic [31:0] w, output bit acc);
    in_valid = 1'b1;
    in_instr = w;
    acc = in_ready;
    if (acc && !w[31]) exp_q.push_back(model(w));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0 && count == 0 && !rs_enable) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!done || count !== 0) begin
      errors++;
      $display("FAIL drain_timeout: count=%0d pending=%0d, required 0/0", count, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, rs_enable, count, stall_cnt, illegal} !== {1'b1, 1'b0, 4'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b en=%b cnt=%0d stall=%0d ill=%b, required 1 0 0 0 0",
               in_ready, rs_enable, count, stall_cnt, illegal);
    end
    checks++;
    if ({rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm} !== '0) begin
      errors++;
      $display("FAIL reset_fields: unit=%0d r1=%0d r2=%0d r3=%0d h=%b imm=%h, required all 0",
               rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_addi;
    bit acc;
    int p0 = pulses;
    push_word(32'h5045_0010, acc);
    checks++;
    if (!acc || count !== 1) begin
      errors++;
      $display("FAIL addi_push: acc=%b count=%0d, required 1 1", acc, count);
    end
    wait_idle(40);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL addi_pulses: got %0d, required 1", pulses - p0);
    end
    checks++;
    if ({rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm} !==
        {2'b10, 6'd1, 6'd5, 6'd0, 1'b1, 32'h0000_0010}) begin
      errors++;
      $display("FAIL addi_fields: unit=%0d r1=%0d r2=%0d r3=%0d h=%b imm=%h, required 2 1 5 0 1 00000010",
               rs_unit, rs_reg1, rs_reg2, rs_reg3, rs_hasimm, rs_imm);
    end
  endtask

  task automatic test_sw_imm;
    bit acc;
    push_word({4'h3, 6'd7, 6'd2, 16'hFFFC}, acc);
    wait_idle(40);
    checks++;
    if ({rs_unit, rs_hasimm, rs_imm, rs_reg3} !== {2'b01, 1'b1, 32'hFFFF_FFFC, 6'd0}) begin
      errors++;
      $display("FAIL swi_fields: unit=%0d h=%b imm=%h r3=%0d, required 1 1 fffffffc 0",
               rs_unit, rs_hasimm, rs_imm, rs_reg3);
    end
  endtask

  task automatic test_retry;
    bit acc;
    int p0 = pulses;
    rej_left = 3;
    push_word({4'h4, 6'd3, 6'd4, 6'd5, 10'h02A}, acc);
    wait_idle(60);
    checks++;
    if (pulses - p0 != 4) begin
      errors++;
      $display("FAIL retry_pulses: got %0d, required 4", pulses - p0);
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL retry_stall: got %0d, required 3", stall_cnt);
    end
    checks++;
    if ({rs_unit, rs_reg3, rs_imm} !== {2'b10, 6'd5, 32'd0}) begin
      errors++;
      $display("FAIL retry_fields: unit=%0d r3=%0d imm=%h, required 2 5 0", rs_unit, rs_reg3, rs_imm);
    end
  endtask

  task automatic test_full_wrap;
    bit acc;
    hold_rs = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic [3:0] op;
      op = 4'(i % 8);
      push_word({op, 6'(i + 10), 6'(i + 20), 6'(i + 30), 10'(i * 37)}, acc);
      checks++;
      if (acc !== (i < 8)) begin
        errors++;
        $display("FAIL full_ready[%0d]: got %b, required %b", i, acc, (i < 8));
      end
    end
    checks++;
    if (count !== 8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_count: count=%0d rdy=%b, required 8 0", count, in_ready);
    end
    hold_rs = 1'b0;
    wait_idle(200);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_drain_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_drop;
    bit acc;
    int p0 = pulses;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre: got %b, required 0", illegal);
    end
    push_word(32'hF000_0000, acc);
    push_word(32'h9ABC_DEF0, acc);
    push_word({4'h6, 6'd9, 6'd10, 6'd11, 10'h0}, acc);
    wait_idle(60);
    checks++;
    if (pulses - p0 != 1 || rs_unit !== 2'b11) begin
      errors++;
      $display("FAIL drop_dispatch: pulses=%0d unit=%0d, required 1 3", pulses - p0, rs_unit);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got %b, required 1", illegal);
    end
  endtask

  task automatic test_reset_mid;
    bit acc;
    bit seen = 1'b0;
    int p0;
    hold_rs = 1'b1;
    for (int i = 0; i < 3; i++) push_word({4'h4, 6'(i + 1), 6'd2, 6'd3, 10'h0}, acc);
    for (int i = 0; i < 20; i++) begin
      if (rs_enable) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midrst_issue: no rs_enable seen, required one");
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rs_enable, count, in_ready, stall_cnt} !== {1'b0, 4'd0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL midrst_state: en=%b cnt=%0d rdy=%b stall=%0d, required 0 0 1 0",
               rs_enable, count, in_ready, stall_cnt);
    end
    exp_q.delete();
    hold_rs = 1'b0;
    rs_accept = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (20) @(negedge clk);
    checks++;
    if (pulses != p0 || count !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: pulses=%0d count=%0d, required 0 0", pulses - p0, count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_addi();
    test_sw_imm();
    test_retry();
    test_full_wrap();
    test_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
